// File: rtl/switch_debounce_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch debounce controller.
// The master drives address and write controls; the slave returns registered read data.
interface switch_debounce_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/switch_debounce_ctrl.sv
// Debounces WIDTH switch inputs, latches edges per MODE into a W1C EDGE register,
// and raises a level interrupt when any unmasked EDGE bit is set.
module switch_debounce_ctrl #(
   parameter int WIDTH      = 8,
   parameter int DEB_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   switch_debounce_ctrl_if.slave bus,
   input  logic [WIDTH-1:0]      in_port,
   output logic                  irq
);

   localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_RISE = 2'b00,
      MODE_FALL = 2'b01,
      MODE_BOTH = 2'b10,
      MODE_OFF  = 2'b11
   } mode_e;

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] db_q, db_d;
   logic [WIDTH-1:0] prev_db_q, prev_db_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   mode_e            mode_q, mode_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;

   logic [WIDTH-1:0] rise, fall, qual, w1c;
   logic             wr_en;
   logic             unused_wdata;

   // Only the low bits of writedata are meaningful for any register.
   assign unused_wdata = ^bus.writedata;
   assign wr_en        = bus.chipselect & ~bus.write_n;

   // Per-bit debounce: counter runs while the synchronized level disagrees with db.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
      logic [15:0] cnt_q, cnt_d;
      logic        db_bit_d;

      always_comb begin
         cnt_d    = '0;
         db_bit_d = db_q[gi];
         if (sync2_q[gi] != db_q[gi]) begin
            if (cnt_q == DEB_LAST) begin
               db_bit_d = sync2_q[gi];
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign db_d[gi] = db_bit_d;
   end

   always_comb begin
      sync1_d   = in_port;
      sync2_d   = sync1_q;
      prev_db_d = db_q;

      rise = db_q & ~prev_db_q;
      fall = ~db_q & prev_db_q;
      case (mode_q)
         MODE_RISE: qual = rise;
         MODE_FALL: qual = fall;
         MODE_BOTH: qual = rise | fall;
         default:   qual = '0;
      endcase

      mask_d = mask_q;
      mode_d = mode_q;
      w1c    = '0;
      if (wr_en) begin
         case (bus.address)
            2'd1:    mask_d = bus.writedata[WIDTH-1:0];
            2'd2:    w1c    = bus.writedata[WIDTH-1:0];
            2'd3:    mode_d = mode_e'(bus.writedata[1:0]);
            default: ;
         endcase
      end

      // A new qualifying edge wins over a same-cycle clear.
      edge_d = (edge_q & ~w1c) | qual;
      irq_d  = |(edge_q & mask_q);

      // Read mux samples the values being registered this edge, so readdata
      // tracks db/EDGE/MASK/MODE without an extra cycle of lag.
      case (bus.address)
         2'd0:    readdata_d = 32'(db_d);
         2'd1:    readdata_d = 32'(mask_d);
         2'd2:    readdata_d = 32'(edge_d);
         default: readdata_d = 32'(mode_d);
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         db_q       <= '0;
         prev_db_q  <= '0;
         mask_q     <= '0;
         edge_q     <= '0;
         mode_q     <= MODE_RISE;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_q       <= db_d;
         prev_db_q  <= prev_db_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         mode_q     <= mode_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Directed bench for switch_debounce_ctrl with DEB_CYCLES=4: register vector table
// followed by hand-written sequences for debounce latency, glitches, modes, W1C and reset.
module tb_switch_debounce_ctrl;

   logic       clk;
   logic       reset_n;
   logic [7:0] in_port;
   logic       irq;
   int         n_total;
   int         n_pass;

   switch_debounce_ctrl_if bus_if ();

   switch_debounce_ctrl #(
      .WIDTH      (8),
      .DEB_CYCLES (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if),
      .in_port (in_port),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cs;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus_if.address    = a;
      bus_if.writedata  = d;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      tick(1);
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;

      vecs[0] = '{1'b1, 1'b1, 2'd1, 32'h0000_00A5, 32'h0000_00A5};
      vecs[1] = '{1'b1, 1'b1, 2'd3, 32'h0000_0007, 32'h0000_0003};
      vecs[2] = '{1'b1, 1'b1, 2'd0, 32'h0000_00FF, 32'h0000_0000};
      vecs[3] = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FF01, 32'h0000_0001};
      vecs[4] = '{1'b0, 1'b1, 2'd1, 32'h0000_0055, 32'h0000_0001};
      vecs[5] = '{1'b1, 1'b0, 2'd2, 32'h0000_00FF, 32'h0000_0000};
      vecs[6] = '{1'b1, 1'b1, 2'd3, 32'h0000_0000, 32'h0000_0000};
      vecs[7] = '{1'b1, 1'b1, 2'd2, 32'h0000_00FF, 32'h0000_0000};

      reset_n           = 1'b0;
      in_port           = 8'h00;
      bus_if.address    = 2'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'h0;
      #1;
      check("reset_readdata", bus_if.readdata, 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      tick(2);
      reset_n = 1'b1;
      tick(2);
      check("reset_data", bus_if.readdata, 32'h0);

      // Register access table
      for (int i = 0; i < 8; i++) begin
         bus_if.address    = vecs[i].addr;
         bus_if.writedata  = vecs[i].wdata;
         bus_if.chipselect = vecs[i].cs;
         bus_if.write_n    = ~vecs[i].wr;
         tick(1);
         bus_if.chipselect = 1'b0;
         bus_if.write_n    = 1'b1;
         tick(1);
         $display("vec %0d: addr=%0d wr=%0b wdata=0x%08h rd=0x%08h", i, vecs[i].addr,
                  vecs[i].wr & vecs[i].cs, vecs[i].wdata, bus_if.readdata);
         check($sformatf("vec%0d_rd", i), bus_if.readdata, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), 32'(irq), 32'h0);
      end

      // Debounce latency on bit0, then EDGE/irq timing and W1C (MASK=0x01, MODE=rise)
      bus_if.address = 2'd0;
      in_port = 8'h01;
      tick(5);
      check("lat_data_before", bus_if.readdata, 32'h00);
      tick(1);
      check("lat_data_at6", bus_if.readdata, 32'h01);
      bus_if.address = 2'd2;
      tick(1);
      check("lat_edge", bus_if.readdata, 32'h01);
      check("irq_not_yet", 32'(irq), 32'h0);
      tick(1);
      check("irq_set", 32'(irq), 32'h1);
      bus_write(2'd2, 32'h01);
      check("w1c_edge", bus_if.readdata, 32'h00);
      check("irq_hold_1", 32'(irq), 32'h1);
      tick(1);
      check("irq_clear_2", 32'(irq), 32'h0);
      $display("seq latency/irq done");

      // 3-cycle glitch on bit2 must be rejected
      bus_if.address = 2'd0;
      in_port = 8'h05;
      tick(3);
      in_port = 8'h01;
      tick(8);
      check("glitch_data", bus_if.readdata, 32'h01);
      bus_if.address = 2'd2;
      tick(1);
      check("glitch_edge", bus_if.readdata, 32'h00);
      check("glitch_irq", 32'(irq), 32'h0);
      $display("seq glitch done");

      // Falling-only mode on bit3, then capture disabled
      bus_write(2'd3, 32'h1);
      bus_if.address = 2'd2;
      in_port = 8'h09;
      tick(8);
      check("fall_mode_after_rise", bus_if.readdata, 32'h00);
      in_port = 8'h01;
      tick(8);
      check("fall_mode_after_fall", bus_if.readdata, 32'h08);
      bus_write(2'd3, 32'h3);
      bus_if.address = 2'd2;
      tick(1);
      check("mode_change_keeps_edge", bus_if.readdata, 32'h08);
      bus_write(2'd2, 32'h08);
      in_port = 8'h09;
      tick(8);
      in_port = 8'h01;
      tick(8);
      check("mode_off_no_capture", bus_if.readdata, 32'h00);
      $display("seq modes done");

      // W1C of EDGE[1] in the same cycle a new bit1 edge qualifies (both-edges mode)
      bus_write(2'd3, 32'h2);
      bus_if.address = 2'd2;
      in_port = 8'h03;
      tick(8);
      check("both_rise_edge", bus_if.readdata, 32'h02);
      in_port = 8'h01;
      tick(6);
      bus_write(2'd2, 32'h02);
      check("w1c_collide_now", bus_if.readdata, 32'h02);
      tick(1);
      check("w1c_collide_hold", bus_if.readdata, 32'h02);
      $display("seq w1c collision done");

      // Reset mid-debounce with irq asserted
      bus_write(2'd3, 32'h0);
      bus_write(2'd1, 32'h03);
      tick(1);
      check("pre_reset_irq", 32'(irq), 32'h1);
      in_port = 8'h07;
      tick(3);
      reset_n = 1'b0;
      #1;
      check("mid_reset_readdata", bus_if.readdata, 32'h0);
      check("mid_reset_irq", 32'(irq), 32'h0);
      tick(2);
      bus_if.address = 2'd1;
      reset_n = 1'b1;
      tick(1);
      check("post_reset_mask", bus_if.readdata, 32'h0);
      bus_if.address = 2'd0;
      tick(4);
      check("post_reset_data_before", bus_if.readdata, 32'h00);
      tick(1);
      check("post_reset_data_at6", bus_if.readdata, 32'h07);
      bus_if.address = 2'd2;
      tick(1);
      check("post_reset_edge", bus_if.readdata, 32'h07);
      bus_if.address = 2'd3;
      tick(1);
      check("post_reset_mode", bus_if.readdata, 32'h0);
      check("post_reset_irq", 32'(irq), 32'h0);
      $display("seq reset done");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
